// File: rtl/multdiv_writeback_if.sv
// Signal bundle between the multdiv completion source, the main W stage and the
// shared register-file write port of multdiv_writeback.
interface multdiv_writeback_if;
  logic [31:0] md_result;
  logic        md_resultRDY;
  logic [31:0] md_instruction;
  logic        md_mult_overflow;
  logic        md_div_error;
  logic        pipe_wb_en;
  logic [4:0]  pipe_wb_reg;
  logic [31:0] pipe_wb_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        md_full;
  logic        pipe_stall;
  logic [1:0]  md_pending;
  logic        md_drop_err;

  // Handshake: md_resultRDY is a one-cycle valid with no ready; md_full is the
  // only back-pressure and the source must not issue while it is high.
  modport master (
    output md_result, md_resultRDY, md_instruction, md_mult_overflow, md_div_error,
    output pipe_wb_en, pipe_wb_reg, pipe_wb_data,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  md_full, pipe_stall, md_pending, md_drop_err
  );

  modport slave (
    input  md_result, md_resultRDY, md_instruction, md_mult_overflow, md_div_error,
    input  pipe_wb_en, pipe_wb_reg, pipe_wb_data,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output md_full, pipe_stall, md_pending, md_drop_err
  );
endinterface

// File: rtl/multdiv_writeback.sv
// Queues multdiv completions and merges them into the shared regfile write port.
// Optional MDWB_BYPASS_EN: zero-latency write of a completion when the FIFO is empty.
module multdiv_writeback #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  multdiv_writeback_if.slave  wb,
  output logic [1:0]          state_dbg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    fifo_reg  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_d;
  logic [WW-1:0] wait_cnt, wait_d;
  logic          full_q, drop_q;

  logic [4:0]  rd_field, new_reg;
  logic [31:0] new_data;
  logic        new_valid, non_empty, force_drain, pipe_req, pipe_owns;
  logic        pop, push_ok, drop, bypass;
  logic        unused_instr;

  assign rd_field     = wb.md_instruction[26:22];
  assign unused_instr = ^{wb.md_instruction[31:27], wb.md_instruction[21:0]};

  // Exceptions redirect to $rstatus; div_error outranks mult_overflow.
  always_comb begin
    new_reg  = rd_field;
    new_data = wb.md_result;
    if (wb.md_div_error) begin
      new_reg  = 5'd30;
      new_data = 32'd5;
    end else if (wb.md_mult_overflow) begin
      new_reg  = 5'd30;
      new_data = 32'd4;
    end
  end

  assign new_valid   = wb.md_resultRDY &&
                       (wb.md_div_error || wb.md_mult_overflow || rd_field != 5'd0);
  assign non_empty   = (count != '0);
  assign force_drain = (state_q == S_FORCE);
  assign pipe_req    = wb.pipe_wb_en && (wb.pipe_wb_reg != 5'd0);
  assign pipe_owns   = pipe_req && !force_drain;
  assign pop         = non_empty && !pipe_owns;

`ifdef MDWB_BYPASS_EN
  assign bypass = !non_empty && !pipe_owns && new_valid;
`else
  assign bypass = 1'b0;
`endif

  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok = new_valid && !bypass && (!full_q || pop);
  assign drop    = new_valid && !bypass && full_q && !pop;

  always_comb begin
    wb.ctrl_writeEnable = 1'b0;
    wb.ctrl_writeReg    = 5'd0;
    wb.data_writeReg    = 32'd0;
    if (pipe_owns) begin
      wb.ctrl_writeEnable = 1'b1;
      wb.ctrl_writeReg    = wb.pipe_wb_reg;
      wb.data_writeReg    = wb.pipe_wb_data;
    end else if (non_empty) begin
      wb.ctrl_writeEnable = 1'b1;
      wb.ctrl_writeReg    = fifo_reg[rd_ptr];
      wb.data_writeReg    = fifo_data[rd_ptr];
    end else if (bypass) begin
      wb.ctrl_writeEnable = 1'b1;
      wb.ctrl_writeReg    = new_reg;
      wb.data_writeReg    = new_data;
    end else if (wb.pipe_wb_en) begin
      wb.ctrl_writeEnable = 1'b1;
      wb.ctrl_writeReg    = wb.pipe_wb_reg;
      wb.data_writeReg    = wb.pipe_wb_data;
    end
  end

  always_comb begin
    count_d = count;
    if (push_ok && !pop) begin
      count_d = count + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count - 1'b1;
    end

    wait_d = wait_cnt;
    if (pop) begin
      wait_d = '0;
    end else if (non_empty && pipe_owns) begin
      wait_d = wait_cnt + 1'b1;
    end

    state_d = state_q;
    if (count_d == '0) begin
      state_d = S_IDLE;
    end else if (wait_d == WW'(STARVE_LIMIT)) begin
      state_d = S_FORCE;
    end else begin
      state_d = S_WAIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      wait_cnt <= wait_d;
      full_q   <= (count_d == CW'(DEPTH));
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)    drop_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_reg[wr_ptr]  <= new_reg;
      fifo_data[wr_ptr] <= new_data;
    end
  end

  assign wb.pipe_stall  = force_drain;
  assign wb.md_full     = full_q;
  assign wb.md_pending  = count[1:0];
  assign wb.md_drop_err = drop_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_multdiv_writeback.sv
// Directed bench for multdiv_writeback: queue-level reference model checked every
// cycle, an ordered scoreboard of multdiv writes, and hand-computed literal checks.
module tb_multdiv_writeback;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] state_dbg_unused;

  multdiv_writeback_if bus ();

  multdiv_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock     (clock),
    .reset     (reset),
    .wb        (bus),
    .state_dbg (state_dbg_unused)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mq[$];
  int          starve = 0;
  bit          drop_m = 1'b0;
  bit          model_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference model: a plain queue of pending {reg,data} writes plus a wait count.
  always @(negedge clock) begin
    logic        pipe_req, force_d, has_e, consumed, popped, exp_we;
    logic [36:0] e;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic [36:0] sb;
    if (model_on) begin
      pipe_req = bus.pipe_wb_en && (bus.pipe_wb_reg != 5'd0);
      force_d  = (mq.size() > 0) && (starve >= LIMIT);
      has_e = 1'b0;
      e     = '0;
      if (bus.md_resultRDY) begin
        if (bus.md_div_error) begin
          has_e = 1'b1; e = {5'd30, 32'd5};
        end else if (bus.md_mult_overflow) begin
          has_e = 1'b1; e = {5'd30, 32'd4};
        end else if (bus.md_instruction[26:22] != 5'd0) begin
          has_e = 1'b1; e = {bus.md_instruction[26:22], bus.md_result};
        end
      end
      consumed = 1'b0;
      popped   = 1'b0;
      if (pipe_req && !force_d) begin
        {exp_we, exp_reg, exp_data} = {1'b1, bus.pipe_wb_reg, bus.pipe_wb_data};
      end else if (mq.size() > 0) begin
        {exp_we, exp_reg, exp_data} = {1'b1, mq[0]};
        popped = 1'b1;
      end
`ifdef MDWB_BYPASS_EN
      else if (has_e) begin
        {exp_we, exp_reg, exp_data} = {1'b1, e};
        consumed = 1'b1;
      end
`endif
      else if (bus.pipe_wb_en) begin
        {exp_we, exp_reg, exp_data} = {1'b1, bus.pipe_wb_reg, bus.pipe_wb_data};
      end else begin
        {exp_we, exp_reg, exp_data} = '0;
      end

      check("model_we", bus.ctrl_writeEnable, exp_we);
      check("model_reg", bus.ctrl_writeReg, exp_reg);
      check("model_data", bus.data_writeReg, exp_data);
      check("model_stall", bus.pipe_stall, force_d);
      check("model_pending", bus.md_pending, mq.size());
      check("model_full", bus.md_full, (mq.size() == DEPTH));
      check("model_drop", bus.md_drop_err, drop_m);

      // Scoreboard: any write that is not the pipe's own must be the next multdiv result.
      if (!reset && bus.ctrl_writeEnable &&
          !(bus.pipe_wb_en && bus.ctrl_writeReg == bus.pipe_wb_reg &&
            bus.data_writeReg == bus.pipe_wb_data)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got r%0d=%0h expected none",
                   bus.ctrl_writeReg, bus.data_writeReg);
        end else begin
          sb = exp_q.pop_front();
          check("sb_write", {bus.ctrl_writeReg, bus.data_writeReg}, sb[31:0]);
          check("sb_reg", bus.ctrl_writeReg, sb[36:32]);
        end
      end

      if (reset) begin
        mq.delete();
        starve = 0;
        drop_m = 1'b0;
      end else begin
        if (popped) begin
          void'(mq.pop_front());
          starve = 0;
        end else if (mq.size() > 0) begin
          starve++;
        end
        if (has_e && !consumed) begin
          if (mq.size() < DEPTH) mq.push_back(e);
          else drop_m = 1'b1;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic md_push(input logic [4:0] rd, input logic [31:0] res,
                         input logic ovf, input logic derr);
    bus.md_resultRDY     = 1'b1;
    bus.md_instruction   = {5'b00011, rd, 22'h2ABCD};
    bus.md_result        = res;
    bus.md_mult_overflow = ovf;
    bus.md_div_error     = derr;
  endtask

  task automatic md_idle();
    bus.md_resultRDY     = 1'b0;
    bus.md_instruction   = 32'd0;
    bus.md_result        = 32'd0;
    bus.md_mult_overflow = 1'b0;
    bus.md_div_error     = 1'b0;
  endtask

  task automatic pipe_set(input logic en, input logic [4:0] rg, input logic [31:0] data);
    bus.pipe_wb_en   = en;
    bus.pipe_wb_reg  = rg;
    bus.pipe_wb_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    md_idle();
    pipe_set(1'b0, 5'd0, 32'd0);
    next_cycle();
    model_on = 1'b1;
    @(negedge clock);
    check("rst_pending", bus.md_pending, 0);
    check("rst_full", bus.md_full, 0);
    check("rst_stall", bus.pipe_stall, 0);
    check("rst_drop", bus.md_drop_err, 0);
    check("rst_we", bus.ctrl_writeEnable, 0);
    next_cycle();
    reset = 1'b0;

    // Mult rd=5 -> 42
    md_push(5'd5, 32'd42, 1'b0, 1'b0);
    exp_q.push_back({5'd5, 32'd42});
    @(negedge clock);
`ifdef MDWB_BYPASS_EN
    check("t1_bypass_reg", bus.ctrl_writeReg, 5);
`else
    check("t1_no_write_yet", bus.ctrl_writeEnable, 0);
`endif
    next_cycle();
    md_idle();
`ifndef MDWB_BYPASS_EN
    @(negedge clock);
    check("t1_we", bus.ctrl_writeEnable, 1);
    check("t1_reg", bus.ctrl_writeReg, 5);
    check("t1_data", bus.data_writeReg, 42);
    check("t1_pending", bus.md_pending, 1);
`endif
    next_cycle();
    @(negedge clock);
    check("t1_pending_back", bus.md_pending, 0);
    next_cycle();

    // Div error rd=7 -> r30=5
    md_push(5'd7, 32'd99, 1'b0, 1'b1);
    exp_q.push_back({5'd30, 32'd5});
    next_cycle();
    md_idle();
`ifndef MDWB_BYPASS_EN
    @(negedge clock);
    check("t2_reg", bus.ctrl_writeReg, 30);
    check("t2_data", bus.data_writeReg, 5);
`endif
    next_cycle();

    // Overflow -> r30=4, both flags -> r30=5, rd=0 -> nothing
    md_push(5'd8, 32'd123, 1'b1, 1'b0);
    exp_q.push_back({5'd30, 32'd4});
    next_cycle();
    md_push(5'd9, 32'd7, 1'b1, 1'b1);
    exp_q.push_back({5'd30, 32'd5});
    next_cycle();
    md_idle();
    next_cycle();
    next_cycle();
    md_push(5'd0, 32'h77, 1'b0, 1'b0);
    next_cycle();
    md_idle();
    @(negedge clock);
    check("rd0_pending", bus.md_pending, 0);
    check("rd0_we", bus.ctrl_writeEnable, 0);
    next_cycle();

    // Starvation: pipe hogs r3 while r9 waits
    pipe_set(1'b1, 5'd3, 32'h333);
    md_push(5'd9, 32'h99, 1'b0, 1'b0);
    exp_q.push_back({5'd9, 32'h99});
    next_cycle();
    md_idle();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      check("t3_pipe_reg", bus.ctrl_writeReg, 3);
      check("t3_no_stall", bus.pipe_stall, 0);
      next_cycle();
    end
    @(negedge clock);
    check("t3_force_reg", bus.ctrl_writeReg, 9);
    check("t3_force_data", bus.data_writeReg, 32'h99);
    check("t3_stall", bus.pipe_stall, 1);
    next_cycle();
    @(negedge clock);
    check("t3_retry_reg", bus.ctrl_writeReg, 3);
    check("t3_retry_data", bus.data_writeReg, 32'h333);
    check("t3_retry_stall", bus.pipe_stall, 0);
    next_cycle();
    pipe_set(1'b0, 5'd0, 32'd0);
    next_cycle();

    // Fill, drop, drain in order
    pipe_set(1'b1, 5'd4, 32'h444);
    md_push(5'd10, 32'hA, 1'b0, 1'b0);
    exp_q.push_back({5'd10, 32'hA});
    next_cycle();
    md_push(5'd11, 32'hB, 1'b0, 1'b0);
    exp_q.push_back({5'd11, 32'hB});
    next_cycle();
    md_push(5'd12, 32'hC, 1'b0, 1'b0);
    @(negedge clock);
    check("t4_full", bus.md_full, 1);
    check("t4_pending", bus.md_pending, 2);
    check("t4_no_drop_yet", bus.md_drop_err, 0);
    next_cycle();
    md_idle();
    pipe_set(1'b0, 5'd0, 32'd0);
    @(negedge clock);
    check("t4_drop", bus.md_drop_err, 1);
    check("t4_first_reg", bus.ctrl_writeReg, 10);
    check("t4_first_data", bus.data_writeReg, 32'hA);
    next_cycle();
    @(negedge clock);
    check("t4_second_reg", bus.ctrl_writeReg, 11);
    check("t4_second_data", bus.data_writeReg, 32'hB);
    check("t4_pending1", bus.md_pending, 1);
    next_cycle();
    @(negedge clock);
    check("t4_pending0", bus.md_pending, 0);
    next_cycle();

    // Reset with two queued entries
    pipe_set(1'b1, 5'd4, 32'h444);
    md_push(5'd16, 32'h10, 1'b0, 1'b0);
    next_cycle();
    md_push(5'd17, 32'h11, 1'b0, 1'b0);
    next_cycle();
    md_idle();
    reset = 1'b1;
    @(negedge clock);
    check("t6_pending_before", bus.md_pending, 2);
    next_cycle();
    reset = 1'b0;
    pipe_set(1'b0, 5'd0, 32'd0);
    @(negedge clock);
    check("t6_pending", bus.md_pending, 0);
    check("t6_full", bus.md_full, 0);
    check("t6_drop", bus.md_drop_err, 0);
    check("t6_we", bus.ctrl_writeEnable, 0);
    next_cycle();
    next_cycle();

    // Full FIFO, push and pop on the same edge
    pipe_set(1'b1, 5'd4, 32'h444);
    md_push(5'd13, 32'hD, 1'b0, 1'b0);
    exp_q.push_back({5'd13, 32'hD});
    next_cycle();
    md_push(5'd14, 32'hE, 1'b0, 1'b0);
    exp_q.push_back({5'd14, 32'hE});
    next_cycle();
    pipe_set(1'b0, 5'd0, 32'd0);
    md_push(5'd15, 32'hF, 1'b0, 1'b0);
    exp_q.push_back({5'd15, 32'hF});
    @(negedge clock);
    check("t5_full", bus.md_full, 1);
    check("t5_head_reg", bus.ctrl_writeReg, 13);
    next_cycle();
    md_idle();
    @(negedge clock);
    check("t5_pending", bus.md_pending, 2);
    check("t5_still_full", bus.md_full, 1);
    check("t5_no_drop", bus.md_drop_err, 0);
    check("t5_next_reg", bus.ctrl_writeReg, 14);
    next_cycle();
    next_cycle();
    next_cycle();

    // Pipe request to r0 does not own the port
    pipe_set(1'b1, 5'd0, 32'h555);
    md_push(5'd20, 32'h20, 1'b0, 1'b0);
    exp_q.push_back({5'd20, 32'h20});
    next_cycle();
    md_idle();
`ifndef MDWB_BYPASS_EN
    @(negedge clock);
    check("r0_head_reg", bus.ctrl_writeReg, 20);
    check("r0_head_data", bus.data_writeReg, 32'h20);
`endif
    next_cycle();
    pipe_set(1'b0, 5'd0, 32'd0);
    next_cycle();
    next_cycle();
    @(negedge clock);
    check("exp_q_drained", exp_q.size(), 0);
    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
